select_biggest_reg: RTL and testbench
=====================================

# select_biggest_reg

Masked maximum selector: among `NUM_WAY` packed unsigned lanes, it returns the largest value whose condition bit is set. It serves replacement and priority logic (age, counter and score comparisons), where a way is picked by value under a mask. Core logic is a combinational masked comparator tree. The result is registered once on `clk_in`, giving fixed 1-cycle latency.

## Interface
- `SINGLE_WAY_WIDTH_IN_BITS`, default 4: width of each lane, unsigned.
- `NUM_WAY`, default 16: number of lanes, must be ≥ 1 (any value, not only powers of two).

- `clk_in`  input  1: clock; all state updates on its rising edge.
- `reset_in`  input  1: reset, asynchronous, active-low.
- `way_flatted_in`  input  `SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY`: packed lanes; lane i = bits [i*W +: W], where W = `SINGLE_WAY_WIDTH_IN_BITS`.
- `condition_in`  input  `NUM_WAY`: bit i enables lane i.
- `select_out`  output  `SINGLE_WAY_WIDTH_IN_BITS`: registered maximum of the enabled lanes.
- `select_valid_out`  output  1: registered; 1 when at least one condition bit was set.

## Operation
- Masking: each lane is forced to 0 when its condition bit is 0. Because comparison is unsigned, a masked lane can never win.
- Reduction:
  - A balanced binary tree of unsigned `>=` comparators reduces the masked lanes to one value.
  - Depth is ceil(log2(`NUM_WAY`)).
  - For non-power-of-two `NUM_WAY`, the tree is padded with zero lanes.
- Ties: equal values are indistinguishable, so only the value is output. No index is output.
- No enabled lane (`condition_in` = 0): result is 0 and `select_valid_out` = 0.
- Enabled lanes all holding 0: result is 0 and `select_valid_out` = 1.
- `select_valid_out` = OR-reduction of `condition_in`.
- No arithmetic is performed and no width growth occurs. Output width equals lane width.

## Timing
- While `reset_in` = 0, asynchronously: `select_out` = 0 and `select_valid_out` = 0.
- Both outputs hold the reset value until the first rising edge after `reset_in` is released.
- Latency: the inputs sampled at rising edge N appear on the outputs after edge N. Latency is 1 cycle with no bubbles.
- A new input set may be applied every cycle (full throughput). There is no handshake or stall.
- Outputs change only on a clock edge or on reset assertion. There is no combinational path from inputs to outputs.
- Reset asserted mid-stream: outputs go to 0 immediately. The in-flight result is discarded.

## Test plan
Lists below are lane 15 down to lane 0, using default parameters. Each check is made one cycle after the input is applied.

1. Reset: hold `reset_in` = 0 with arbitrary inputs -> `select_out` = 0, `select_valid_out` = 0. Release reset and apply the first input -> result appears after the first edge.
2. Masked maximum, case 1: lanes {a,b,c,d,5,2,3,4,5,2,3,4,a,b,a,5}, `condition_in` = 16'b1110_0111_1110_0111 -> `select_out` = 4'hc. The larger value d is masked off and must not win. `select_valid_out` = 1.
3. Masked maximum, case 2: lanes {5,8,7,c,2,9,3,4,2,9,3,4,5,8,7,a}, `condition_in` = 16'b1011_0111_1111_1111 -> `select_out` = 4'hc, with lane 0 (a) enabled but smaller.
4. Empty mask and single lane:
   - `condition_in` = 0 with all lanes f -> `select_out` = 0, `select_valid_out` = 0.
   - `condition_in` = 16'h0001, lane 0 = 7, all other lanes f -> `select_out` = 7.
5. Extremes and ties: all lanes f with mask 16'hffff -> f. All lanes 0 with mask 16'hffff -> `select_out` = 0, `select_valid_out` = 1.
6. Throughput: apply case 2, case 3, then case 4 on consecutive cycles -> outputs c, c, 0 on consecutive cycles. Assert reset mid-sequence -> outputs 0 immediately.

Source files
------------

// File: rtl/select_biggest_reg.sv
// Masked maximum selector: the largest lane value whose condition bit is set,
// reduced through a balanced comparator tree and registered once.
module select_biggest_reg #(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
    parameter int NUM_WAY                  = 16
) (
    input  logic                                         clk_in,
    input  logic                                         reset_in,
    input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_flatted_in,
    input  logic [NUM_WAY-1:0]                           condition_in,
    output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]          select_out,
    output logic                                         select_valid_out
);

    localparam int W      = SINGLE_WAY_WIDTH_IN_BITS;
    localparam int LEVELS = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 0;
    localparam int PAD    = 1 << LEVELS;
    localparam int PAD_W  = PAD * W;

    logic [PAD-1:0]   cond_pad;
    logic [PAD_W-1:0] lanes_pad;
    logic [W-1:0]     node [2*PAD-1];
    logic [W-1:0]     max_value;

    // Heap layout: leaves at PAD-1.., node k has children 2k+1 and 2k+2.
    // Padding lanes carry a zero condition bit, so they are masked to 0.
    always_comb begin
        cond_pad  = PAD'(condition_in);
        lanes_pad = PAD_W'(way_flatted_in);
        for (int unsigned i = 0; i < 2*PAD-1; i++) begin
            node[i] = '0;
        end
        for (int unsigned i = 0; i < PAD; i++) begin
            node[PAD-1+i] = cond_pad[i] ? lanes_pad[i*W +: W] : '0;
        end
        for (int unsigned k = PAD-1; k > 0; k--) begin
            node[k-1] = (node[2*k-1] >= node[2*k]) ? node[2*k-1] : node[2*k];
        end
        max_value = node[0];
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            select_out       <= '0;
            select_valid_out <= 1'b0;
        end else begin
            select_out       <= max_value;
            select_valid_out <= |condition_in;
        end
    end

endmodule

// File: tb/tb_select_biggest_reg.sv
// Directed bench for select_biggest_reg with default parameters (16 lanes x 4 bits).
module tb_select_biggest_reg;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic [63:0] way_flatted_in;
    logic [15:0] condition_in;
    logic [3:0]  select_out;
    logic        select_valid_out;

    int passed = 0;
    int total  = 0;

    select_biggest_reg #(
        .SINGLE_WAY_WIDTH_IN_BITS(4),
        .NUM_WAY(16)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .way_flatted_in(way_flatted_in),
        .condition_in(condition_in),
        .select_out(select_out),
        .select_valid_out(select_valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [3:0] exp_sel, input logic exp_vld);
        total++;
        assert (select_out === exp_sel && select_valid_out === exp_vld) passed++;
        else $error("FAIL %s: observed sel=%h vld=%b expected sel=%h vld=%b",
                    tag, select_out, select_valid_out, exp_sel, exp_vld);
    endtask

    task automatic drive(input logic [63:0] lanes, input logic [15:0] cond);
        way_flatted_in = lanes;
        condition_in   = cond;
    endtask

    initial begin
        reset_in = 1'b0;
        drive(64'hffff_ffff_ffff_ffff, 16'hffff);
        #3;
        check("reset_async", 4'h0, 1'b0);
        @(negedge clk_in);
        check("reset_held_over_edge", 4'h0, 1'b0);

        reset_in = 1'b1;
        #1;
        check("after_release_no_edge", 4'h0, 1'b0);
        drive(64'habcd_5234_5234_aba5, 16'he7e7);
        @(negedge clk_in);
        check("case1_masked_d", 4'hc, 1'b1);

        drive(64'h587c_2934_2934_587a, 16'hb7ff);
        #1;
        check("no_comb_path", 4'hc, 1'b1);
        @(negedge clk_in);
        check("case2", 4'hc, 1'b1);

        drive(64'hffff_ffff_ffff_ffff, 16'h0000);
        @(negedge clk_in);
        check("empty_mask", 4'h0, 1'b0);

        drive(64'hffff_ffff_ffff_fff7, 16'h0001);
        @(negedge clk_in);
        check("single_lane0", 4'h7, 1'b1);

        drive(64'h3fff_ffff_ffff_ffff, 16'h8000);
        @(negedge clk_in);
        check("single_lane15", 4'h3, 1'b1);

        drive(64'h1111_1111_1111_111e, 16'hffff);
        @(negedge clk_in);
        check("max_at_lane0", 4'he, 1'b1);

        drive(64'hffff_ffff_ffff_ffff, 16'hffff);
        @(negedge clk_in);
        check("all_f", 4'hf, 1'b1);

        drive(64'h0000_0000_0000_0000, 16'hffff);
        @(negedge clk_in);
        check("all_zero_valid", 4'h0, 1'b1);

        // Back-to-back inputs, one result per cycle.
        drive(64'habcd_5234_5234_aba5, 16'he7e7);
        @(negedge clk_in);
        check("stream_case1", 4'hc, 1'b1);
        drive(64'h587c_2934_2934_587a, 16'hb7ff);
        @(negedge clk_in);
        check("stream_case2", 4'hc, 1'b1);
        drive(64'hffff_ffff_ffff_ffff, 16'h0000);
        @(negedge clk_in);
        check("stream_empty", 4'h0, 1'b0);
        drive(64'hffff_ffff_ffff_ffff, 16'hffff);
        @(negedge clk_in);
        check("stream_all_f", 4'hf, 1'b1);

        // Mid-stream reset discards the held result immediately.
        drive(64'habcd_5234_5234_aba5, 16'he7e7);
        #2;
        reset_in = 1'b0;
        #1;
        check("midstream_reset", 4'h0, 1'b0);
        @(negedge clk_in);
        check("midstream_reset_held", 4'h0, 1'b0);
        reset_in = 1'b1;
        drive(64'h587c_2934_2934_587a, 16'hb7ff);
        @(negedge clk_in);
        check("post_reset_case2", 4'hc, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
